im_fetch_sequencer: RTL and testbench

Upstream address sequencer for the item memory block.
- Accepts burst fetch requests over a valid/ready handshake.
- Drives the item memory port A address, port B address and CiM select.
- Captures the two returned hypervectors into a registered output stage, which presents them downstream (to the encoder/bundler) with valid/ready and a last flag.
- The item memory is combinational; this block supplies the register boundary on both sides of it.

---
 rtl/im_fetch_pkg.sv | 22 ++
 rtl/im_fetch_out_reg.sv | 39 +++
 rtl/im_fetch_sequencer.sv | 141 ++++++++++++++
 tb/tb_im_fetch_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/im_fetch_pkg.sv
// Shared types and constants for the item-memory fetch sequencer.
package im_fetch_pkg;

  localparam int unsigned PerfCntWidth = 32;

  // The request bundle is sized for the default geometry (1024 entries, 8-bit burst length).
  localparam int unsigned ReqAddrWidth = 10;
  localparam int unsigned ReqLenWidth  = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ReqAddrWidth-1:0] addr_a;
    logic [ReqAddrWidth-1:0] addr_b;
    logic                    cim;
    logic [ReqLenWidth-1:0]  len;
  } fetch_req_t;

endpackage

// File: rtl/im_fetch_out_reg.sv
// Output register stage: one A/B hypervector pair plus last flag behind a valid/ready handshake.
module im_fetch_out_reg #(
  parameter int unsigned Width = 512
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             capture_i,
  input  logic             last_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             ready_i,
  output logic             can_accept_o,
  output logic             valid_o,
  output logic             last_o,
  output logic [Width-1:0] a_o,
  output logic [Width-1:0] b_o
);

  // A capture in the same cycle as a drain simply replaces the drained beat.
  assign can_accept_o = !valid_o || ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      a_o     <= '0;
      b_o     <= '0;
    end else if (capture_i) begin
      valid_o <= 1'b1;
      last_o  <= last_i;
      a_o     <= a_i;
      b_o     <= b_i;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end
  end

endmodule

// File: rtl/im_fetch_sequencer.sv
// Burst address sequencer in front of the combinational item memory, with a registered output stage.
// Optional perf counters (beat/stall) are built when IM_FETCH_PERF_CNT_EN is defined.
//
// state | meaning
// IDLE  | ready for a request; addresses hold the previous burst's values
// FETCH | one beat captured per cycle the output stage can accept
module im_fetch_sequencer
  import im_fetch_pkg::*;
#(
  parameter int unsigned HVDimension = 512,
  parameter int unsigned NumTotIm    = 1024,
  parameter int unsigned BurstWidth  = 8,
  parameter int unsigned ImAddrWidth = $clog2(NumTotIm)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [ImAddrWidth-1:0] req_addr_a_i,
  input  logic [ImAddrWidth-1:0] req_addr_b_i,
  input  logic                   req_cim_i,
  input  logic [BurstWidth-1:0]  req_len_i,
  output logic [ImAddrWidth-1:0] im_a_addr_o,
  output logic [ImAddrWidth-1:0] im_b_addr_o,
  output logic                   port_a_cim_o,
  input  logic [HVDimension-1:0] im_a_i,
  input  logic [HVDimension-1:0] im_b_i,
  output logic                   hv_valid_o,
  input  logic                   hv_ready_i,
  output logic [HVDimension-1:0] hv_a_o,
  output logic [HVDimension-1:0] hv_b_o,
  output logic                   hv_last_o,
`ifdef IM_FETCH_PERF_CNT_EN
  input  logic                    perf_clr_i,
  output logic [PerfCntWidth-1:0] beat_cnt_o,
  output logic [PerfCntWidth-1:0] stall_cnt_o,
`endif
  output logic                   busy_o
);

  fetch_state_e           state_q, state_d;
  fetch_req_t             req;
  logic [BurstWidth-1:0]  remaining_q, remaining_d;
  logic [ImAddrWidth-1:0] addr_a_d, addr_b_d;
  logic                   cim_d;
  logic                   fire;
  logic                   can_accept;
  logic                   last_beat;

  assign req = '{addr_a: ReqAddrWidth'(req_addr_a_i),
                 addr_b: ReqAddrWidth'(req_addr_b_i),
                 cim:    req_cim_i,
                 len:    ReqLenWidth'(req_len_i)};

  assign req_ready_o = (state_q == IDLE);
  assign last_beat   = (remaining_q == '0);
  assign busy_o      = (state_q != IDLE) || hv_valid_o;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_a_d    = im_a_addr_o;
    addr_b_d    = im_b_addr_o;
    cim_d       = port_a_cim_o;
    fire        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_a_d    = ImAddrWidth'(req.addr_a);
          addr_b_d    = ImAddrWidth'(req.addr_b);
          cim_d       = req.cim;
          remaining_d = BurstWidth'(req.len);
          state_d     = FETCH;
        end
      end
      FETCH: begin
        if (can_accept) begin
          fire = 1'b1;
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            remaining_d = remaining_q - BurstWidth'(1);
            // Explicit wrap keeps non-power-of-two memory depths legal.
            addr_a_d = (im_a_addr_o == ImAddrWidth'(NumTotIm - 1)) ? '0
                                                                   : im_a_addr_o + ImAddrWidth'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      im_a_addr_o  <= '0;
      im_b_addr_o  <= '0;
      port_a_cim_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      im_a_addr_o  <= addr_a_d;
      im_b_addr_o  <= addr_b_d;
      port_a_cim_o <= cim_d;
    end
  end

  im_fetch_out_reg #(
    .Width (HVDimension)
  ) u_out_reg (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .capture_i    (fire),
    .last_i       (last_beat),
    .a_i          (im_a_i),
    .b_i          (im_b_i),
    .ready_i      (hv_ready_i),
    .can_accept_o (can_accept),
    .valid_o      (hv_valid_o),
    .last_o       (hv_last_o),
    .a_o          (hv_a_o),
    .b_o          (hv_b_o)
  );

`ifdef IM_FETCH_PERF_CNT_EN
  // Saturating counters; a clear takes priority over any same-cycle increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || perf_clr_i) begin
      beat_cnt_o  <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (hv_valid_o && hv_ready_i && !(&beat_cnt_o))
        beat_cnt_o <= beat_cnt_o + PerfCntWidth'(1);
      if (hv_valid_o && !hv_ready_i && !(&stall_cnt_o))
        stall_cnt_o <= stall_cnt_o + PerfCntWidth'(1);
    end
  end
`endif

endmodule

// File: tb/tb_im_fetch_sequencer.sv
// Self-checking bench for im_fetch_sequencer: vector table, directed corner sequences and a
// randomized run against a beat-queue reference model. Perf checks build with IM_FETCH_PERF_CNT_EN.
`timescale 1ns/1ps
module tb_im_fetch_sequencer;

  localparam int HV  = 512;
  localparam int NUM = 1024;
  localparam int BW  = 8;
  localparam int AW  = 10;
  localparam int CW  = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_a = '0, req_b = '0;
  logic          req_cim = 1'b0;
  logic [BW-1:0] req_len = '0;
  logic [AW-1:0] im_a_addr, im_b_addr;
  logic          port_a_cim;
  logic [HV-1:0] im_a, im_b;
  logic          hv_valid, hv_last, busy;
  logic          hv_ready = 1'b0;
  logic [HV-1:0] hv_a, hv_b;
`ifdef IM_FETCH_PERF_CNT_EN
  logic          perf_clr = 1'b0;
  logic [31:0]   beat_cnt, stall_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  im_fetch_sequencer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_a_i (req_a),
    .req_addr_b_i (req_b),
    .req_cim_i    (req_cim),
    .req_len_i    (req_len),
    .im_a_addr_o  (im_a_addr),
    .im_b_addr_o  (im_b_addr),
    .port_a_cim_o (port_a_cim),
    .im_a_i       (im_a),
    .im_b_i       (im_b),
    .hv_valid_o   (hv_valid),
    .hv_ready_i   (hv_ready),
    .hv_a_o       (hv_a),
    .hv_b_o       (hv_b),
    .hv_last_o    (hv_last),
`ifdef IM_FETCH_PERF_CNT_EN
    .perf_clr_i   (perf_clr),
    .beat_cnt_o   (beat_cnt),
    .stall_cnt_o  (stall_cnt),
`endif
    .busy_o       (busy)
  );

  // Combinational item memory stand-in: distinct content per address and per CiM mode.
  function automatic logic [HV-1:0] mem_a(input logic [AW-1:0] addr, input logic cim);
    logic [HV-1:0] v;
    for (int i = 0; i < HV / 32; i++)
      v[i*32 +: 32] = ((32'(addr) + 32'd1) * 32'h9E37_79B1) ^ (32'(i) << 20) ^ (cim ? 32'hC1C1_0000 : 32'h0);
    return v;
  endfunction

  function automatic logic [HV-1:0] mem_b(input logic [AW-1:0] addr);
    logic [HV-1:0] v;
    for (int i = 0; i < HV / 32; i++)
      v[i*32 +: 32] = ((32'(addr) + 32'd7) * 32'h85EB_CA6B) ^ (32'(i) << 24) ^ 32'h5A5A_A5A5;
    return v;
  endfunction

  assign im_a = mem_a(im_a_addr, port_a_cim);
  assign im_b = mem_b(im_b_addr);

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: every accepted request expands into its list of expected beats.
  typedef struct packed {
    logic [AW-1:0] a;
    logic          cim;
    logic [AW-1:0] b;
    logic          last;
  } beat_t;

  beat_t sb[$];
  int    beats_seen = 0;

  task automatic run_cycle(input logic rv, input int a, input int b, input logic cim,
                           input int len, input logic rdy);
    logic          stall;
    logic [HV-1:0] ha, hb;
    logic          hl;
    logic [AW-1:0] aa;
    logic          in_fetch;
    beat_t         e;
    req_valid = rv;
    req_a     = AW'(a);
    req_b     = AW'(b);
    req_cim   = cim;
    req_len   = BW'(len);
    hv_ready  = rdy;
    if (rv && req_ready) begin
      for (int k = 0; k <= len; k++) begin
        e.a    = AW'((a + k) % NUM);
        e.cim  = cim;
        e.b    = AW'(b);
        e.last = (k == len);
        sb.push_back(e);
      end
    end
    if (hv_valid && rdy) begin
      beats_seen++;
      chk("beat_expected", CW'(sb.size() > 0), CW'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("beat_hv_a", CW'(hv_a), CW'(mem_a(e.a, e.cim)));
        chk("beat_hv_b", CW'(hv_b), CW'(mem_b(e.b)));
        chk("beat_last", CW'(hv_last), CW'(e.last));
      end
    end
    stall    = hv_valid && !rdy;
    in_fetch = !req_ready;
    ha = hv_a; hb = hv_b; hl = hv_last; aa = im_a_addr;
    tick();
    if (stall) begin
      chk("stall_valid_held", CW'(hv_valid), CW'(1));
      chk("stall_a_held", CW'(hv_a), CW'(ha));
      chk("stall_b_held", CW'(hv_b), CW'(hb));
      chk("stall_last_held", CW'(hv_last), CW'(hl));
      if (in_fetch) chk("stall_addr_frozen", CW'(im_a_addr), CW'(aa));
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      run_cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
      n++;
    end
    chk("drain_sb_empty", CW'(sb.size()), CW'(0));
    chk("drain_not_busy", CW'(busy), CW'(0));
  endtask

  typedef struct {
    logic          rv;
    logic [AW-1:0] a, b;
    logic          cim;
    logic [BW-1:0] len;
    logic          rdy;
    logic          e_rr, e_v, e_l, e_busy;
    logic [AW-1:0] e_ia, e_ib;
    logic          e_cim;
    logic [AW-1:0] e_da;
  } vec_t;

  function automatic vec_t mkv(input int rv, input int a, input int b, input int cim, input int len,
                               input int rdy, input int e_rr, input int e_v, input int e_l,
                               input int e_busy, input int e_ia, input int e_ib, input int e_cim,
                               input int e_da);
    vec_t v;
    v.rv = rv[0]; v.a = AW'(a); v.b = AW'(b); v.cim = cim[0]; v.len = BW'(len); v.rdy = rdy[0];
    v.e_rr = e_rr[0]; v.e_v = e_v[0]; v.e_l = e_l[0]; v.e_busy = e_busy[0];
    v.e_ia = AW'(e_ia); v.e_ib = AW'(e_ib); v.e_cim = e_cim[0]; v.e_da = AW'(e_da);
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int   ready_pat[16];
    logic pend;
    int   pa, pb, plen;
    logic pcim;
    int   reqs_done;
    int   cyc;

    // rv a b cim len rdy | req_ready valid last busy im_a im_b cim data_addr
    vt[0] = mkv(1,  5, 9, 0, 0, 1,  0, 0, 0, 1,   5, 9, 0,  0);
    vt[1] = mkv(0,  0, 0, 0, 0, 1,  1, 1, 1, 1,   5, 9, 0,  5);
    vt[2] = mkv(0,  0, 0, 0, 0, 1,  1, 0, 0, 0,   5, 9, 0,  0);
    vt[3] = mkv(1, 10, 3, 1, 2, 1,  0, 0, 0, 1,  10, 3, 1,  0);
    vt[4] = mkv(0,  0, 0, 0, 0, 1,  0, 1, 0, 1,  11, 3, 1, 10);
    vt[5] = mkv(0,  0, 0, 0, 0, 1,  0, 1, 0, 1,  12, 3, 1, 11);
    vt[6] = mkv(0,  0, 0, 0, 0, 1,  1, 1, 1, 1,  12, 3, 1, 12);
    vt[7] = mkv(0,  0, 0, 0, 0, 1,  1, 0, 0, 0,  12, 3, 1,  0);

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_req_ready", CW'(req_ready), CW'(1));
    chk("rst_hv_valid", CW'(hv_valid), CW'(0));
    chk("rst_hv_last", CW'(hv_last), CW'(0));
    chk("rst_hv_a", CW'(hv_a), CW'(0));
    chk("rst_im_a_addr", CW'(im_a_addr), CW'(0));
    chk("rst_im_b_addr", CW'(im_b_addr), CW'(0));
    chk("rst_cim", CW'(port_a_cim), CW'(0));
    chk("rst_busy", CW'(busy), CW'(0));
    rst = 1'b0;

    // Single beat then CiM burst, cycle by cycle
    for (int i = 0; i < 8; i++) begin
      req_valid = vt[i].rv; req_a = vt[i].a; req_b = vt[i].b; req_cim = vt[i].cim;
      req_len = vt[i].len; hv_ready = vt[i].rdy;
      tick();
      chk($sformatf("vec%0d_req_ready", i), CW'(req_ready), CW'(vt[i].e_rr));
      chk($sformatf("vec%0d_hv_valid", i), CW'(hv_valid), CW'(vt[i].e_v));
      chk($sformatf("vec%0d_hv_last", i), CW'(hv_last), CW'(vt[i].e_l));
      chk($sformatf("vec%0d_busy", i), CW'(busy), CW'(vt[i].e_busy));
      chk($sformatf("vec%0d_im_a_addr", i), CW'(im_a_addr), CW'(vt[i].e_ia));
      chk($sformatf("vec%0d_im_b_addr", i), CW'(im_b_addr), CW'(vt[i].e_ib));
      chk($sformatf("vec%0d_cim", i), CW'(port_a_cim), CW'(vt[i].e_cim));
      if (vt[i].e_v) begin
        chk($sformatf("vec%0d_hv_a", i), CW'(hv_a), CW'(mem_a(vt[i].e_da, vt[i].e_cim)));
        chk($sformatf("vec%0d_hv_b", i), CW'(hv_b), CW'(mem_b(vt[i].e_ib)));
      end
    end

    // Address wrap across the top of the memory
    req_valid = 1'b1; req_a = AW'(1020); req_b = AW'(77); req_cim = 1'b0; req_len = BW'(7);
    hv_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("wrap%0d_im_a_addr", k), CW'(im_a_addr), CW'((1020 + k) % NUM));
      tick();
      chk($sformatf("wrap%0d_hv_valid", k), CW'(hv_valid), CW'(1));
      chk($sformatf("wrap%0d_hv_a", k), CW'(hv_a), CW'(mem_a(AW'((1020 + k) % NUM), 1'b0)));
      chk($sformatf("wrap%0d_hv_last", k), CW'(hv_last), CW'(k == 7));
    end
    tick();
    chk("wrap_done_busy", CW'(busy), CW'(0));

    // Backpressure with a toggling ready
    ready_pat = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 1, 1};
    beats_seen = 0;
    run_cycle(1'b1, 200, 50, 1'b0, 3, 1'b1);
    for (int c = 0; c < 16; c++) run_cycle(1'b0, 0, 0, 1'b0, 0, ready_pat[c][0]);
    drain(40);
    chk("bp_beat_count", CW'(beats_seen), CW'(4));

    // Reset in the middle of a burst, while beat 3 is presented
    run_cycle(1'b1, 300, 20, 1'b1, 7, 1'b1);
    for (int c = 0; c < 3; c++) run_cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
    chk("midrst_pre_valid", CW'(hv_valid), CW'(1));
    chk("midrst_pre_beat3", CW'(hv_a), CW'(mem_a(AW'(302), 1'b1)));
    rst = 1'b1; hv_ready = 1'b0;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("midrst_req_ready", CW'(req_ready), CW'(1));
    chk("midrst_hv_valid", CW'(hv_valid), CW'(0));
    chk("midrst_im_a_addr", CW'(im_a_addr), CW'(0));
    chk("midrst_im_b_addr", CW'(im_b_addr), CW'(0));
    chk("midrst_cim", CW'(port_a_cim), CW'(0));
    tick();
    chk("midrst_still_idle", CW'(busy), CW'(0));

    // Randomized traffic against the reference model
    pend = 1'b0; pa = 0; pb = 0; pcim = 1'b0; plen = 0; reqs_done = 0; cyc = 0;
    while (reqs_done < 60 && cyc < 4000) begin
      if (!pend && $urandom_range(0, 9) < 4) begin
        pend = 1'b1;
        pa   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1010, 1023)) : int'($urandom_range(0, 1023));
        pb   = int'($urandom_range(0, 1023));
        pcim = $urandom_range(0, 1) == 1;
        plen = int'($urandom_range(0, 12));
      end
      if (pend && req_ready) begin
        pend = 1'b0;
        reqs_done++;
        run_cycle(1'b1, pa, pb, pcim, plen, $urandom_range(0, 3) != 0);
      end else begin
        run_cycle(pend, pa, pb, pcim, plen, $urandom_range(0, 3) != 0);
      end
      cyc++;
    end
    chk("rand_requests_issued", CW'(reqs_done), CW'(60));
    drain(400);

`ifdef IM_FETCH_PERF_CNT_EN
    // Perf counters: clear, then a 10-beat burst with exactly 4 stalled cycles
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    chk("perf_clr_beat", CW'(beat_cnt), CW'(0));
    chk("perf_clr_stall", CW'(stall_cnt), CW'(0));
    run_cycle(1'b1, 40, 41, 1'b0, 9, 1'b1);
    run_cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
    for (int c = 0; c < 8; c++) run_cycle(1'b0, 0, 0, 1'b0, 0, c[0]);
    drain(40);
    chk("perf_beat_cnt", CW'(beat_cnt), CW'(10));
    chk("perf_stall_cnt", CW'(stall_cnt), CW'(4));
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    chk("perf_clr2_beat", CW'(beat_cnt), CW'(0));
    chk("perf_clr2_stall", CW'(stall_cnt), CW'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
